// File: rtl/system_bus_ram_if.sv
// system_bus_ram_if: request/response bundle between a bus master and system_bus_ram.
//   master drives  : bus_addr, bus_write_data, bus_byte_enable, bus_write_req, bus_read_req
//   slave drives   : bus_ready, bus_read_data, bus_read_data_valid, protocol_error
interface system_bus_ram_if;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_write_data;
  logic [BE_W-1:0]   bus_byte_enable;
  logic              bus_write_req;
  logic              bus_read_req;
  logic [DATA_W-1:0] bus_read_data;
  logic              bus_read_data_valid;
  logic              protocol_error;

  modport master (
    input  bus_ready, bus_read_data, bus_read_data_valid, protocol_error,
    output bus_addr, bus_write_data, bus_byte_enable, bus_write_req, bus_read_req
  );

  modport slave (
    output bus_ready, bus_read_data, bus_read_data_valid, protocol_error,
    input  bus_addr, bus_write_data, bus_byte_enable, bus_write_req, bus_read_req
  );

endinterface

// File: rtl/system_bus_ram.sv
// system_bus_ram: single-port 32-bit word RAM on a ready/request bus with byte
// lane writes, pipelined fixed-latency reads and optional wait states.
//   clk      : sole clock, rising edge
//   reset_n  : synchronous active-low reset (memory contents are preserved)
//   bus      : system_bus_ram_if.slave (requests in, ready/read data/error out)
// Parameters: ADDR_BITS (depth 2**ADDR_BITS words), READ_LATENCY (1..4),
//             WAIT_STATES (0..7 ready-low cycles after each accepted request).
module system_bus_ram #(
  parameter int unsigned ADDR_BITS    = 12,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  system_bus_ram_if.slave       bus
);

  localparam int unsigned DEPTH  = 1 << ADDR_BITS;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LAT    = READ_LATENCY;

  typedef enum logic [0:0] {ST_READY = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   perr_q, perr_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic [LAT-1:0]         pipe_vld_q, pipe_vld_d;
  logic [DATA_W-1:0]      pipe_data_q [LAT];
  logic [DATA_W-1:0]      pipe_data_d [LAT];

  logic [DATA_W-1:0]      mem_q [DEPTH];

  logic                   accept_c;
  logic                   wr_acc_c;
  logic                   rd_acc_c;
  logic [ADDR_BITS-1:0]   idx_c;
  logic [DATA_W-1:0]      rd_word_c;
  logic                   unused_addr_hi;

  // Upper address bits alias onto the same words.
  assign idx_c          = bus.bus_addr[ADDR_BITS-1:0];
  assign unused_addr_hi = ^bus.bus_addr[29:ADDR_BITS];

  // Acceptance; requests seen on a reset edge are dropped.
  assign accept_c  = reset_n & ready_q & (bus.bus_read_req | bus.bus_write_req);
  assign wr_acc_c  = accept_c & bus.bus_write_req;
  assign rd_acc_c  = accept_c & bus.bus_read_req & ~bus.bus_write_req;
  assign rd_word_c = mem_q[idx_c];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: leave WAIT on the edge where the counter steps off 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_READY: begin
        if (accept_c && (WAIT_STATES != 0)) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_READY;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // FSM output: ready is registered so it reads 0 throughout reset cycles.
  always_comb begin
    ready_d = (state_d == ST_READY);
  end

  // Read pipeline, output hold and sticky protocol error.
  always_comb begin
    perr_d        = perr_q | (accept_c & bus.bus_read_req & bus.bus_write_req);
    pipe_vld_d    = pipe_vld_q;
    pipe_data_d   = pipe_data_q;
    pipe_vld_d[0]  = rd_acc_c;
    pipe_data_d[0] = rd_word_c;
    for (int unsigned i = 1; i < LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
    rvalid_d = pipe_vld_q[LAT-1];
    rdata_d  = pipe_vld_q[LAT-1] ? pipe_data_q[LAT-1] : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready_q    <= 1'b0;
      perr_q     <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      ready_q     <= ready_d;
      perr_q      <= perr_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
    end
  end

  // Storage array: byte-lane writes, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        if (bus.bus_byte_enable[n]) begin
          mem_q[idx_c][8*n +: 8] <= bus.bus_write_data[8*n +: 8];
        end
      end
    end
  end

  assign bus.bus_ready           = ready_q;
  assign bus.bus_read_data       = rdata_q;
  assign bus.bus_read_data_valid = rvalid_q;
  assign bus.protocol_error      = perr_q;

endmodule
